// File: rtl/nios_system_pio_pulse_out.sv
// ---------------------------------------------------------------------------
// nios_system_pio_pulse_out
//
// Avalon-MM output port for the Nios II data master. Drives WIDTH output
// bits; each bit is either a plain level output or a self-timed one-shot
// pulse whose length comes from a shared, programmable PLEN register.
// SET and CLEAR registers give software bitwise updates without a
// read-modify-write sequence.
//
// Bus behaviour: zero-wait-state slave. A write is accepted on every clock
// edge where chipselect=1 and write_n=0; there is no waitrequest. Reads are
// combinational from address alone (chipselect is not consulted).
//
// Register map (word addresses):
//   0 DATA   R/W  level bits take writedata, pulse bits with 1 trigger
//   1 MODE   R/W  0 = level, 1 = pulse, per bit
//   2 SET    W    level bits OR in writedata, pulse bits with 1 trigger
//   3 CLEAR  W    all bits AND NOT writedata, pulse bits with 1 abort
//   4 PLEN   R/W  pulse length in cycles (0 is stored as 1)
//   5 STATUS RO   bit i = pulse on bit i still counting
//   6,7      read 0, writes ignored
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high
//   address    word address [2:0]
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  write data (low WIDTH or CW bits used)
//   readdata   read data, zero-extended to 32 bits
//   out_port   WIDTH output bits
// ---------------------------------------------------------------------------
module nios_system_pio_pulse_out #(
   parameter int WIDTH         = 8,
   parameter int CW            = 16,
   parameter int PULSE_DEFAULT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);

   localparam logic [2:0] ADDR_DATA   = 3'd0;
   localparam logic [2:0] ADDR_MODE   = 3'd1;
   localparam logic [2:0] ADDR_SET    = 3'd2;
   localparam logic [2:0] ADDR_CLEAR  = 3'd3;
   localparam logic [2:0] ADDR_PLEN   = 3'd4;
   localparam logic [2:0] ADDR_STATUS = 3'd5;

   localparam logic [CW-1:0] PLEN_RST = CW'(PULSE_DEFAULT);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [WIDTH-1:0] data_out_q, data_out_d;
   logic [WIDTH-1:0] mode_q, mode_d;
   logic [CW-1:0]    cnt_q [WIDTH];
   logic [CW-1:0]    cnt_d [WIDTH];
   logic [CW-1:0]    plen_q, plen_d;

   logic             we;
   logic             wr_data, wr_mode, wr_set, wr_clear, wr_plen;
   logic [WIDTH-1:0] wdata;
   logic [CW-1:0]    wplen;
   logic [WIDTH-1:0] status;

   // Only the low WIDTH/CW bits of writedata carry information.
   logic             unused_wr_bits;
   assign unused_wr_bits = ^writedata;

   assign we       = chipselect && !write_n;
   assign wr_data  = we && (address == ADDR_DATA);
   assign wr_mode  = we && (address == ADDR_MODE);
   assign wr_set   = we && (address == ADDR_SET);
   assign wr_clear = we && (address == ADDR_CLEAR);
   assign wr_plen  = we && (address == ADDR_PLEN);
   assign wdata    = writedata[WIDTH-1:0];
   assign wplen    = writedata[CW-1:0];

   always_comb begin
      status = '0;
      for (int i = 0; i < WIDTH; i++) begin
         status[i] = (cnt_q[i] != '0);
      end
   end

   // Next-state logic. Behaviour of every bit is decided by the mode that
   // is already registered, so a MODE write only takes effect next edge.
   always_comb begin
      data_out_d = data_out_q;
      mode_d     = mode_q;
      plen_d     = plen_q;
      cnt_d      = cnt_q;

      for (int i = 0; i < WIDTH; i++) begin
         if (mode_q[i]) begin
            // Pulse bit. Priority: abort, trigger, mode drop, countdown.
            if (wr_clear && wdata[i]) begin
               data_out_d[i] = 1'b0;
               cnt_d[i]      = '0;
            end else if ((wr_data || wr_set) && wdata[i]) begin
               // Retrigger simply reloads; the output never drops.
               data_out_d[i] = 1'b1;
               cnt_d[i]      = plen_q;
            end else if (wr_mode && !wdata[i]) begin
               // Leaving pulse mode freezes the output at its present value.
               cnt_d[i]      = '0;
            end else if (cnt_q[i] != '0) begin
               cnt_d[i] = cnt_q[i] - CNT_ONE;
               if (cnt_q[i] == CNT_ONE) begin
                  data_out_d[i] = 1'b0;
               end
            end
         end else begin
            // Level bit; its counter is always idle.
            cnt_d[i] = '0;
            if (wr_data) begin
               data_out_d[i] = wdata[i];
            end else if (wr_set && wdata[i]) begin
               data_out_d[i] = 1'b1;
            end else if (wr_clear && wdata[i]) begin
               data_out_d[i] = 1'b0;
            end
         end
      end

      if (wr_mode) begin
         mode_d = wdata;
      end

      if (wr_plen) begin
         plen_d = (wplen == '0) ? CNT_ONE : wplen;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_out_q <= '0;
         mode_q     <= '0;
         plen_q     <= PLEN_RST;
         cnt_q      <= '{default: '0};
      end else begin
         data_out_q <= data_out_d;
         mode_q     <= mode_d;
         plen_q     <= plen_d;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA:   readdata = 32'(data_out_q);
         ADDR_MODE:   readdata = 32'(mode_q);
         ADDR_PLEN:   readdata = 32'(plen_q);
         ADDR_STATUS: readdata = 32'(status);
         default:     readdata = '0;
      endcase
   end

   assign out_port = data_out_q;

endmodule
